// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command stage for the lab SR flip-flop.
// Two raw push-button levels (set, clear) are turned into clean,
// single-cycle S and R pulses. Each channel is synchronised, debounced
// and rising-edge detected. A set edge and a clear edge that qualify in
// the same cycle cancel each other and raise a conflict flag instead, so
// S and R are never both high.

// ---------------------------------------------------------------------------
// One input channel: two-flop synchroniser, debounce counter, edge detect.
// ---------------------------------------------------------------------------
module sr_cmd_gen_chan #(
  parameter int DB_CNT = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic rise
);

  // Last count value before the debounced level is allowed to flip.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             db_r;
  logic             db_d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             db_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Two-flop synchroniser; only sync2_r is used further downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce decision: a mismatch must persist DB_CNT edges to flip the level.
  always_comb begin
    db_nxt_s  = db_r;
    cnt_nxt_s = cnt_r;
    if (sync2_r == db_r) begin
      // Any return to the accepted level discards the partial count.
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      db_nxt_s  = sync2_r;
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Debounced level, its one-cycle history, and the stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r   <= 1'b0;
      db_d_r <= 1'b0;
      cnt_r  <= CNT_ZERO;
    end else begin
      db_r   <= db_nxt_s;
      db_d_r <= db_r;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Only a 0->1 change of the debounced level is a command; falls are ignored.
  assign rise = db_r & ~db_d_r;

endmodule

// ---------------------------------------------------------------------------
// Top level: two channels feeding a registered, mutually exclusive output.
// ---------------------------------------------------------------------------
module sr_cmd_gen #(
  parameter int DB_CNT = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic clr_in,
  output logic S,
  output logic R,
  output logic conflict
);

  logic set_rise_s;
  logic clr_rise_s;
  logic s_nxt_s;
  logic r_nxt_s;
  logic conflict_nxt_s;

  sr_cmd_gen_chan #(
    .DB_CNT (DB_CNT),
    .CNT_W  (CNT_W)
  ) u_set_chan (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (set_in),
    .rise   (set_rise_s)
  );

  sr_cmd_gen_chan #(
    .DB_CNT (DB_CNT),
    .CNT_W  (CNT_W)
  ) u_clr_chan (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (clr_in),
    .rise   (clr_rise_s)
  );

  // Arbitrate the two edges; simultaneous edges issue nothing but a flag.
  always_comb begin
    s_nxt_s        = 1'b0;
    r_nxt_s        = 1'b0;
    conflict_nxt_s = 1'b0;
    case ({set_rise_s, clr_rise_s})
      2'b10: begin
        s_nxt_s = 1'b1;
      end
      2'b01: begin
        r_nxt_s = 1'b1;
      end
      2'b11: begin
        conflict_nxt_s = 1'b1;
      end
      default: begin
        s_nxt_s        = 1'b0;
        r_nxt_s        = 1'b0;
        conflict_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset forces the flip-flop into hold immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= s_nxt_s;
      R        <= r_nxt_s;
      conflict <= conflict_nxt_s;
    end
  end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop in the lab SR_FF design.
- Converts two raw, asynchronous, bouncy push-button levels (set request, clear request) into clean, single-cycle, mutually exclusive S and R pulses.
- Each input is synchronised, debounced and rising-edge detected.
- Guarantees the forbidden S=R=1 combination never reaches the flip-flop.

Parameters:
- DB_CNT, 4: consecutive stable cycles required before a synchronised input is accepted; legal range 2..2^CNT_W.
- CNT_W, 3: width of each debounce counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- set_in  input  1  raw set request, asynchronous to clk, may bounce.
- clr_in  input  1  raw clear request, asynchronous to clk, may bounce.
- S  output  1  registered set pulse to the SR flip-flop; one cycle wide.
- R  output  1  registered reset pulse to the SR flip-flop; one cycle wide.
- conflict  output  1  registered one-cycle flag: set and clear edges qualified in the same cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchroniser flops, debounced levels, edge-history flops and counters all go to 0.
  - S=0, R=0, conflict=0.
  - Release is synchronous to the next clk edge; no pulses are generated from pre-reset history.
- Synchroniser: two-flop chain per input (x_s1, x_s2); x_s2 is the only value used downstream.
- Debounce (per channel, independent), on each edge:
  - If x_s2 == db: cnt <= 0.
  - Else if cnt == DB_CNT-1: db <= x_s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A mismatch must persist DB_CNT consecutive edges to flip db. Any return to match clears cnt, so glitches shorter than DB_CNT cycles are discarded.
- Edge detect: db_d registered copy of db; rise = db & ~db_d. Falling edges produce nothing.
- Output register, on each edge:
  - set_rise only: S<=1, R<=0.
  - clr_rise only: S<=0, R<=1.
  - Both: S<=0, R<=0, conflict<=1. Neither command is issued; the flip-flop holds.
  - Neither: S<=0, R<=0, conflict<=0.
- Invariant: S & R is never 1 in any cycle, including during and after reset.
- Latency: if set_in rises before edge k and stays high, then:
  - x_s1=1 after edge k; x_s2=1 after k+1.
  - db=1 after edge k+1+DB_CNT.
  - S=1 after edge k+2+DB_CNT, for exactly one cycle (7 edges with DB_CNT=4).
  - Same latency for clr_in/R.
- Held input: one pulse per press regardless of hold length. A new pulse requires db to return to 0, which needs DB_CNT stable-low cycles.
- Reset mid-debounce: counters and db clear; a press still held after release is re-qualified from scratch (full latency again).
- Counter never exceeds DB_CNT-1, so no wrap-around.

Test Plan:
- Clean set, clk period 20, DB_CNT=4: reset until t=7, set_in=1 held from t=7 -> S high for exactly one cycle, 7 edges after first sampling edge; R=0, conflict=0 throughout; no second pulse while held.
- Bounce filter: clr_in toggles 1/0/1 with 1–2 cycle widths, then stable 1 -> no R during bouncing; single R pulse DB_CNT+3 edges after the last transition; S stays 0.
- Glitch reject: set_in high for 3 cycles (< DB_CNT) then low -> S, R, conflict remain 0.
- Simultaneous: set_in and clr_in rise together and hold -> conflict=1 for one cycle; S=0, R=0 every cycle; flip-flop Q unchanged.
- Sequence into SR_ff: set press, release (≥6 cycles low), clear press -> Q goes 1 then 0; Q_bar always the complement; S and R never both 1.
- Reset mid-operation: set_in held, rst_n pulsed low 2 cycles during count -> S=0 immediately; after release, S pulses once with full latency measured from reset release.
